// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scanner with dead-time ghost suppression, frame-coherent latch; SEG_BLINK_EN adds per-slot blink.
// Latency: an/seg registered, 1 cycle after the div_cnt/idx state they reflect.
// Backpressure: none; inputs sampled at frame boundaries only, en=0 freezes scan and blanks.
module seg_scan_driver #(
    parameter int SCAN_DIV = 1000,
    parameter int DEAD_CYC = 4
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 50
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] hrs_t,
    input  logic [7:0] hrs_o,
    input  logic [7:0] min_t,
    input  logic [7:0] min_o,
    input  logic [7:0] sec_t,
    input  logic [7:0] sec_o,
    input  logic       colon,
`ifdef SEG_BLINK_EN
    input  logic [5:0] blink_mask,
`endif
    output logic [7:0] seg,
    output logic [5:0] an
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYC);

    logic [CW-1:0]   div_cnt;
    logic [2:0]      idx;
    logic            primed;
    logic [5:0][7:0] dig_l;
    logic            colon_l;
    logic            slot_end;
    logic            frame_end;
    logic            latch_now;
    logic            blank_slot;
    logic [5:0]      an_nxt;
    logic [7:0]      seg_nxt;

    function automatic logic [6:0] decode(input logic [7:0] v);
        case (v)
            8'd0:    decode = 7'h3F;
            8'd1:    decode = 7'h06;
            8'd2:    decode = 7'h5B;
            8'd3:    decode = 7'h4F;
            8'd4:    decode = 7'h66;
            8'd5:    decode = 7'h6D;
            8'd6:    decode = 7'h7D;
            8'd7:    decode = 7'h07;
            8'd8:    decode = 7'h7F;
            8'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (idx == 3'd5);
    // Capture on the very first enabled edge so frame 0 does not show stale zeros.
    assign latch_now = en && (!primed || frame_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else if (en) begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed  <= 1'b0;
            dig_l   <= '0;
            colon_l <= 1'b0;
        end else if (latch_now) begin
            primed  <= 1'b1;
            dig_l   <= {sec_o, sec_t, min_o, min_t, hrs_o, hrs_t};
            colon_l <= colon;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;
    logic          phase;
    logic [5:0]    mask_l;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
            mask_l    <= 6'h00;
        end else begin
            if (latch_now) begin
                mask_l <= blink_mask;
            end
            if (en && frame_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign blank_slot = phase && mask_l[idx];
`else
    assign blank_slot = 1'b0;
`endif

    always_comb begin
        an_nxt  = 6'h3F;
        seg_nxt = 8'h00;
        if (en && (div_cnt >= DEAD_LIM) && !blank_slot) begin
            an_nxt  = ~(6'b000001 << idx);
            seg_nxt = {colon_l && ((idx == 3'd1) || (idx == 3'd3)), decode(dig_l[idx])};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 6'h3F;
            seg <= 8'h00;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan timing, decode, colon, frame latch, enable freeze, async reset.
module tb_seg_scan_driver;

    localparam int SD = 8;
    localparam int DC = 2;
`ifdef SEG_BLINK_EN
    localparam int BF = 2;
    logic [5:0] blink_mask = 6'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] hrs_t = 8'd0, hrs_o = 8'd0, min_t = 8'd0, min_o = 8'd0, sec_t = 8'd0, sec_o = 8'd0;
    logic       colon = 1'b0;
    logic [7:0] seg;
    logic [5:0] an;

    int checks = 0;
    int errors = 0;

    // Expected-behaviour model: scan position before the next edge and the frame being displayed.
    int         m_slot, m_pos;
    bit         m_primed;
    logic [6:0] shown [6];
    logic       shown_col;
    int         m_frame;
    bit         m_phase;
    logic [5:0] shown_mask;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV(SD),
        .DEAD_CYC(DC)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .hrs_t(hrs_t),
        .hrs_o(hrs_o),
        .min_t(min_t),
        .min_o(min_o),
        .sec_t(sec_t),
        .sec_o(sec_o),
        .colon(colon),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg),
        .an(an)
    );

    function automatic logic [6:0] enc(input logic [7:0] v);
        case (v)
            8'd0:    enc = 7'h3F;
            8'd1:    enc = 7'h06;
            8'd2:    enc = 7'h5B;
            8'd3:    enc = 7'h4F;
            8'd4:    enc = 7'h66;
            8'd5:    enc = 7'h6D;
            8'd6:    enc = 7'h7D;
            8'd7:    enc = 7'h07;
            8'd8:    enc = 7'h7F;
            8'd9:    enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    endfunction

    task automatic model_reset();
        m_slot = 0; m_pos = 0; m_primed = 0;
        for (int i = 0; i < 6; i++) shown[i] = 7'h00;
        shown_col = 1'b0; m_frame = 0; m_phase = 0; shown_mask = 6'h00;
    endtask

    task automatic set_digits(input int a, input int b, input int c, input int d, input int e, input int f);
        hrs_t = 8'(a); hrs_o = 8'(b); min_t = 8'(c); min_o = 8'(d); sec_t = 8'(e); sec_o = 8'(f);
    endtask

    task automatic calc_exp(output logic [5:0] ea, output logic [7:0] es);
        logic blank;
        blank = 1'b0;
        ea = 6'h3F;
        es = 8'h00;
`ifdef SEG_BLINK_EN
        blank = m_phase && shown_mask[m_slot];
`endif
        if (en && m_pos >= DC && !blank) begin
            ea = ~(6'b000001 << m_slot);
            es = {shown_col && (m_slot == 1 || m_slot == 3), shown[m_slot]};
        end
    endtask

    // One clock: advance the model on the edge, return at the following negedge for sampling.
    task automatic tick();
        bit wrap;
        @(posedge clk);
        if (rst && en) begin
            wrap = (m_slot == 5 && m_pos == SD - 1);
            if (!m_primed || wrap) begin
                shown[0] = enc(hrs_t); shown[1] = enc(hrs_o); shown[2] = enc(min_t);
                shown[3] = enc(min_o); shown[4] = enc(sec_t); shown[5] = enc(sec_o);
                shown_col = colon;
`ifdef SEG_BLINK_EN
                shown_mask = blink_mask;
                if (wrap) begin
                    if (m_frame == BF - 1) begin m_frame = 0; m_phase = !m_phase; end
                    else m_frame++;
                end
`endif
            end
            m_primed = 1;
            if (m_pos == SD - 1) begin
                m_pos = 0;
                m_slot = (m_slot == 5) ? 0 : m_slot + 1;
            end else begin
                m_pos++;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        en  = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] ea;
        logic [7:0] es;
        int guard;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 6'h3F || seg !== 8'h00)
            begin errors++; $display("FAIL reset_idle an=%h seg=%h expected an=3f seg=00", an, seg); end
        set_digits(1, 2, 3, 4, 5, 6);
        colon = 1'b0;
        model_reset();
        rst = 1'b1;
        en  = 1'b1;
        guard = 0;
        while (!(m_slot == 3 && m_pos == 5) && guard < 200) begin tick(); guard++; end
        checks++;
        if (guard >= 200 || an !== 6'h37 || seg !== 8'h66)
            begin errors++; $display("FAIL reset_preslot3 an=%h seg=%h expected an=37 seg=66", an, seg); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (an !== 6'h3F || seg !== 8'h00)
            begin errors++; $display("FAIL reset_async an=%h seg=%h expected an=3f seg=00", an, seg); end
        @(negedge clk);
        checks++;
        if (an !== 6'h3F || seg !== 8'h00)
            begin errors++; $display("FAIL reset_held an=%h seg=%h expected an=3f seg=00", an, seg); end
        model_reset();
        rst = 1'b1;
        for (int c = 0; c < SD; c++) begin
            calc_exp(ea, es);
            tick();
            checks++;
            if (an !== ea || seg !== es)
                begin errors++; $display("FAIL reset_restart c=%0d an=%h seg=%h expected an=%h seg=%h", c, an, seg, ea, es); end
        end
    endtask

    task automatic test_digits();
        logic [5:0] ea;
        logic [7:0] es;
        set_digits(1, 2, 3, 4, 5, 6);
        colon = 1'b0;
        apply_reset();
        for (int c = 0; c < 6 * SD; c++) begin
            calc_exp(ea, es);
            tick();
            checks++;
            if (an !== ea || seg !== es)
                begin errors++; $display("FAIL digits c=%0d an=%h seg=%h expected an=%h seg=%h", c, an, seg, ea, es); end
            if (c == 2) begin
                checks++;
                if (an !== 6'h3E || seg !== 8'h06)
                    begin errors++; $display("FAIL digits_slot0 an=%h seg=%h expected an=3e seg=06", an, seg); end
            end
            if (c == 42) begin
                checks++;
                if (an !== 6'h1F || seg !== 8'h7D)
                    begin errors++; $display("FAIL digits_slot5 an=%h seg=%h expected an=1f seg=7d", an, seg); end
            end
        end
    endtask

    task automatic test_colon();
        logic [5:0] ea;
        logic [7:0] es;
        set_digits(1, 2, 3, 4, 5, 6);
        colon = 1'b1;
        apply_reset();
        for (int c = 0; c < 6 * SD; c++) begin
            calc_exp(ea, es);
            tick();
            checks++;
            if (an !== ea || seg !== es)
                begin errors++; $display("FAIL colon c=%0d an=%h seg=%h expected an=%h seg=%h", c, an, seg, ea, es); end
            if (c == 10 || c == 26 || c == 2 || c == 34) begin
                checks++;
                if ((c == 10 && seg !== 8'hDB) || (c == 26 && seg !== 8'hE6) ||
                    (c == 2 && seg !== 8'h06) || (c == 34 && seg !== 8'h6D))
                    begin errors++; $display("FAIL colon_dp c=%0d seg=%h", c, seg); end
            end
        end
        colon = 1'b0;
    endtask

    task automatic test_frame_latch();
        logic [5:0] ea;
        logic [7:0] es;
        set_digits(1, 2, 3, 4, 5, 6);
        colon = 1'b0;
        apply_reset();
        for (int c = 0; c < 12 * SD; c++) begin
            calc_exp(ea, es);
            tick();
            checks++;
            if (an !== ea || seg !== es)
                begin errors++; $display("FAIL latch c=%0d an=%h seg=%h expected an=%h seg=%h", c, an, seg, ea, es); end
            if (c == 42) begin
                checks++;
                if (seg !== 8'h7D) begin errors++; $display("FAIL latch_old_sec c=%0d seg=%h expected 7d", c, seg); end
            end
            if (c == 66) begin
                checks++;
                if (an !== 6'h3B || seg !== 8'h40) begin errors++; $display("FAIL latch_dash an=%h seg=%h expected an=3b seg=40", an, seg); end
            end
            if (c == 90) begin
                checks++;
                if (seg !== 8'h6F) begin errors++; $display("FAIL latch_new_sec c=%0d seg=%h expected 6f", c, seg); end
            end
            if (c == 18) begin
                sec_o = 8'd9;
                min_t = 8'd12;
            end
        end
    endtask

    task automatic test_enable();
        logic [5:0] ea;
        logic [7:0] es;
        set_digits(1, 2, 3, 4, 5, 6);
        colon = 1'b0;
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            en = !(c >= 36 && c < 56);
            calc_exp(ea, es);
            tick();
            checks++;
            if (an !== ea || seg !== es)
                begin errors++; $display("FAIL enable c=%0d an=%h seg=%h expected an=%h seg=%h", c, an, seg, ea, es); end
            if (c == 45 || c == 55) begin
                checks++;
                if (an !== 6'h3F || seg !== 8'h00) begin errors++; $display("FAIL enable_blank c=%0d an=%h seg=%h", c, an, seg); end
            end
            if (c == 56) begin
                checks++;
                if (an !== 6'h2F || seg !== 8'h6D) begin errors++; $display("FAIL enable_resume an=%h seg=%h expected an=2f seg=6d", an, seg); end
            end
            if (c == 62) begin
                checks++;
                if (an !== 6'h1F || seg !== 8'h7D) begin errors++; $display("FAIL enable_next an=%h seg=%h expected an=1f seg=7d", an, seg); end
            end
        end
        en = 1'b1;
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        logic [5:0] ea;
        logic [7:0] es;
        set_digits(1, 2, 3, 4, 5, 6);
        colon = 1'b0;
        blink_mask = 6'b000011;
        apply_reset();
        for (int c = 0; c < 30 * SD; c++) begin
            calc_exp(ea, es);
            tick();
            checks++;
            if (an !== ea || seg !== es)
                begin errors++; $display("FAIL blink c=%0d an=%h seg=%h expected an=%h seg=%h", c, an, seg, ea, es); end
            if (c == 2 || c == 194) begin
                checks++;
                if (an !== 6'h3E || seg !== 8'h06) begin errors++; $display("FAIL blink_on c=%0d an=%h seg=%h", c, an, seg); end
            end
            if (c == 98 || c == 106) begin
                checks++;
                if (an !== 6'h3F || seg !== 8'h00) begin errors++; $display("FAIL blink_off c=%0d an=%h seg=%h", c, an, seg); end
            end
            if (c == 114) begin
                checks++;
                if (an !== 6'h3B || seg !== 8'h4F) begin errors++; $display("FAIL blink_other c=%0d an=%h seg=%h", c, an, seg); end
            end
        end
        blink_mask = 6'h00;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_digits();
        test_colon();
        test_frame_latch();
        test_enable();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
